// File: rtl/fetch_queue.sv
// fetch_queue: in-order prefetch buffer with redirect flush; buffered latency = memory + 1 (0 with FETCH_QUEUE_BYPASS_EN).
// Backpressure: requests are issued only while buffered + live in-flight entries leave a free slot; inst_ready stalls the head.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:2] RESET_PC = 30'h0
) (
   input  logic        clk,
   input  logic        _reset,
   input  logic        redirect,
   input  logic [31:2] redirect_pc,
   output logic        mem_req,
   output logic [31:2] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:2] inst_pc,
   input  logic        inst_ready
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [4:0]    DEPTH_C   = 5'(DEPTH);
   localparam logic [4:0]    MAX_OUT_C = 5'(MAX_OUT);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [31:2]   fpc;
   logic [4:0]    count;
   logic [4:0]    outst;
   logic [4:0]    drop;
   logic [4:0]    kept;
   logic          started;

   logic [31:0]   data_q [DEPTH];
   logic [31:2]   pc_q   [DEPTH];
   logic [31:2]   iss_pc_q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] iss_wr;
   logic [AW-1:0] iss_rd;

   logic          issue;
   logic          rsp;
   logic          rsp_keep;
   logic          byp;
   logic          pop;
   logic          pop_buf;
   logic          push;
   logic [31:2]   rsp_pc;

   // Responses still owed to the current fetch stream; stale ones are excluded.
   assign kept     = outst - drop;
   assign mem_req  = started && !redirect && (kept < MAX_OUT_C) && ((count + kept) < DEPTH_C);
   assign mem_addr = fpc;
   assign issue    = mem_req && mem_gnt;

   // A response with nothing outstanding is ignored.
   assign rsp      = mem_rvalid && (outst != 5'd0);
   assign rsp_keep = rsp && (drop == 5'd0) && !redirect;
   assign rsp_pc   = iss_pc_q[iss_rd];

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = rsp_keep && (count == 5'd0);
`else
   assign byp = 1'b0;
`endif

   assign inst_valid = !redirect && (byp || (count != 5'd0));
   assign inst       = !inst_valid ? 32'd0 : (byp ? mem_rdata : data_q[head]);
   assign inst_pc    = !inst_valid ? 30'd0 : (byp ? rsp_pc : pc_q[head]);

   assign pop     = inst_valid && inst_ready;
   assign pop_buf = pop && !byp;
   // A bypassed instruction consumed in the same cycle never occupies a slot.
   assign push    = rsp_keep && !(byp && inst_ready);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         started <= 1'b0;
         fpc     <= RESET_PC;
         count   <= 5'd0;
         outst   <= 5'd0;
         drop    <= 5'd0;
         head    <= '0;
         tail    <= '0;
         iss_wr  <= '0;
         iss_rd  <= '0;
      end else begin
         started <= 1'b1;
         outst   <= outst + {4'd0, issue} - {4'd0, rsp};
         if (issue) iss_wr <= iss_wr + PTR_ONE;
         if (rsp)   iss_rd <= iss_rd + PTR_ONE;
         if (redirect) begin
            // Everything in flight is stale, except a response landing now, which is dropped here.
            fpc   <= redirect_pc;
            count <= 5'd0;
            head  <= '0;
            tail  <= '0;
            drop  <= outst - {4'd0, rsp};
         end else begin
            if (issue) fpc <= fpc + 30'd1;
            if (rsp && (drop != 5'd0)) drop <= drop - 5'd1;
            if (push)    tail <= tail + PTR_ONE;
            if (pop_buf) head <= head + PTR_ONE;
            count <= count + {4'd0, push} - {4'd0, pop_buf};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[tail] <= mem_rdata;
         pc_q[tail]   <= rsp_pc;
      end
      if (issue) iss_pc_q[iss_wr] <= fpc;
   end

`ifndef SYNTHESIS
   a_rvalid_outst : assert property (@(posedge clk) disable iff (!_reset) !(mem_rvalid && (outst == 5'd0)))
      else $error("fetch_queue: mem_rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with variable latency feeding a scoreboard of expected (pc, instruction) pairs.
// Redirects retire stale requests by epoch; directed phases cover reset, fill, stall, flush, random stalls and bypass timing.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 3;
   localparam logic [31:2] RESET_PC = 30'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:2] redirect_pc;
   logic        mem_req;
   logic [31:2] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:2] inst_pc;
   logic        inst_ready;

   typedef struct { logic [31:2] addr; int due; int ep; } req_t;
   typedef struct { logic [31:2] pc; logic [31:0] dat; } exp_t;

   req_t rsp_q[$];
   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int epoch = 0;
   int live = 0;
   int n_pop = 0;
   int gnt_pct = 100;
   int rv_pct = 100;
   int lat_min = 1;
   int lat_max = 1;
   int last_pop_cyc = 0;
   int last_rsp_cyc = 0;
   int rel_cyc = 0;
   int base = 0;
   bit rand_ready = 1'b0;

   logic [31:2] exp_addr;
   logic        obs_req, obs_valid, obs_pop, obs_rvalid;
   logic [31:2] obs_addr, obs_pc;

   fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), ._reset(rst_n),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] img(input logic [31:2] a);
      return {a, 2'b11} ^ 32'h9E37_79B9;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: starts and ends at a falling edge; inputs settle, outputs are sampled 1 time unit later.
   task automatic step();
      req_t e;
      exp_t x;
      if (rand_ready) inst_ready = ($urandom_range(0, 3) != 0);
      mem_gnt    = ($urandom_range(0, 99) < gnt_pct);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      if (rsp_q.size() != 0 && rsp_q[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
         mem_rvalid = 1'b1;
         mem_rdata  = img(rsp_q[0].addr);
      end
      #1;
      obs_req    = mem_req;
      obs_addr   = mem_addr;
      obs_valid  = inst_valid;
      obs_pc     = inst_pc;
      obs_pop    = inst_valid && inst_ready;
      obs_rvalid = mem_rvalid;
      if (redirect) begin
         chk("redir_req_low", mem_req, 1'b0);
         chk("redir_valid_low", inst_valid, 1'b0);
         epoch++;
         sb.delete();
         live = 0;
         exp_addr = redirect_pc;
      end
      if (mem_req && mem_gnt) begin
         chk("req_addr", mem_addr, exp_addr);
         chk("credit", (sb.size() + live < DEPTH) && (live < MAX_OUT), 1'b1);
         rsp_q.push_back('{addr: mem_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), ep: epoch});
         live++;
         exp_addr = exp_addr + 30'd1;
      end
      if (mem_rvalid) begin
         e = rsp_q.pop_front();
         if (e.ep == epoch) begin
            sb.push_back('{pc: e.addr, dat: img(e.addr)});
            live--;
            last_rsp_cyc = cyc;
         end
      end
      if (obs_pop) begin
         chk("pop_expected", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("inst_pc", inst_pc, x.pc);
            chk("inst", inst, x.dat);
         end
         n_pop++;
         last_pop_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_pop(input string tag, input int budget);
      int k;
      step();
      k = 1;
      while (!obs_pop && k < budget) begin
         step();
         k++;
      end
      chk(tag, obs_pop, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 30'd0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0; inst_ready = 1'b1; exp_addr = RESET_PC;

      // Reset state
      @(negedge clk); @(negedge clk); #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 30'd0);
      chk("rst_mem_addr", mem_addr, RESET_PC);
      @(negedge clk);
      rst_n = 1'b1;
      rel_cyc = cyc;

      // Back-to-back fetch with a 1-cycle memory
      step();
      chk("release_req_low", obs_req, 1'b0);
      step();
      chk("first_req", obs_req, 1'b1);
      wait_pop("first_pop_seen", 10);
      chk("first_pop_cycle", last_pop_cyc - rel_cyc, 3 - BYP);
      chk("first_pop_pc", obs_pc, RESET_PC);
      repeat (3) step();
      base = n_pop;
      repeat (20) step();
      chk("throughput", n_pop - base, 20);

      // Consumer stall fills the buffer exactly
      inst_ready = 1'b0;
      repeat (12) step();
      chk("stall_buffered", sb.size(), DEPTH);
      chk("stall_inflight", rsp_q.size(), 0);
      chk("stall_req_low", obs_req, 1'b0);
      inst_ready = 1'b1;
      repeat (10) step();

      // Redirect with two requests outstanding
      lat_min = 5; lat_max = 5; gnt_pct = 100;
      redirect = 1'b1; redirect_pc = 30'h80; step(); redirect = 1'b0;
      step(); step();
      gnt_pct = 0;
      chk("two_outstanding", live, 2);
      lat_min = 1; lat_max = 1; gnt_pct = 100;
      redirect = 1'b1; redirect_pc = 30'h100; step(); redirect = 1'b0;
      step();
      chk("post_redir_req", obs_req, 1'b1);
      chk("post_redir_addr", obs_addr, 30'h100);
      wait_pop("redir_pop_seen", 30);
      chk("redir_first_pc", obs_pc, 30'h100);

      // Redirect colliding with a response and a pop
      repeat (8) step();
      redirect = 1'b1; redirect_pc = 30'h200; step(); redirect = 1'b0;
      chk("redir_rsp_same_cycle", obs_rvalid, 1'b1);
      step();
      chk("post_redir2_valid", obs_valid, 1'b0);
      chk("post_redir2_addr", obs_addr, 30'h200);
      wait_pop("redir2_pop_seen", 20);
      chk("redir2_first_pc", obs_pc, 30'h200);

      // Random grant/response/consumer stalls
      gnt_pct = 70; rv_pct = 80; lat_min = 1; lat_max = 5; rand_ready = 1'b1;
      base = n_pop;
      for (int k = 0; k < 20000 && (n_pop - base) < 1000; k++) step();
      rand_ready = 1'b0; inst_ready = 1'b1;
      chk("random_1000_done", (n_pop - base) >= 1000, 1'b1);

      // Asynchronous reset mid-operation
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_req", mem_req, 1'b0);
      chk("arst_inst_valid", inst_valid, 1'b0);
      chk("arst_mem_addr", mem_addr, RESET_PC);
      rsp_q.delete(); sb.delete(); live = 0; exp_addr = RESET_PC;
      mem_rvalid = 1'b0; mem_gnt = 1'b0; rv_pct = 100;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Single response into an empty queue: bypass timing
      gnt_pct = 100; lat_min = 2; lat_max = 2;
      step();
      chk("rel2_req_low", obs_req, 1'b0);
      step();
      gnt_pct = 0;
      wait_pop("byp_pop_seen", 10);
      chk("byp_latency", last_pop_cyc - last_rsp_cyc, 1 - BYP);
      chk("byp_pc", obs_pc, RESET_PC);
      step();
      chk("byp_after_valid", obs_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
